// File: rtl/gray_conv_arbiter.sv
// Round-robin front end that time-shares one registered binary<->gray converter
// among N_REQ requesters and returns tagged results on a valid/ready response port.
module gray_conv_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    conv_op,
  output logic [DATA_W-1:0]       conv_din,
  input  logic [DATA_W-1:0]       conv_dout,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_op,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [ID_W:0] N_REQ_C = (ID_W+1)'(N_REQ);

  // Both operands are < N_REQ, so a single conditional subtract gives the modulo.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= N_REQ_C) sum = sum - N_REQ_C;
    return sum[ID_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              conv_op_q;
  logic [DATA_W-1:0] conv_din_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic              rsp_op_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [DATA_W-1:0] req_data_a [N_REQ];
  logic [ID_W-1:0]   cand_idx   [N_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;

  // cand_idx[k] is the requester examined k places after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_data_a[gi] = req_data[gi*DATA_W +: DATA_W];
      assign cand_idx[gi]   = wrap_add(rr_ptr_q, (ID_W+1)'(gi));
      assign req_ready[gi]  = rst_n && accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Walk from the farthest candidate back to the pointer so the nearest valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          accept   = 1'b1;
          rr_ptr_d = wrap_add(grant_idx, (ID_W+1)'(1));
          state_d  = CONV;
        end
      end
      CONV:    state_d = CAPT;
      CAPT:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      conv_op_q   <= 1'b0;
      conv_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_op_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        conv_op_q  <= req_op[grant_idx];
        conv_din_q <= req_data_a[grant_idx];
        rsp_id_q   <= grant_idx;
      end
      // The converter result is valid during CAPT, one cycle after its inputs were registered.
      if (state_q == CAPT) begin
        rsp_data_q  <= conv_dout;
        rsp_op_q    <= conv_op_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign conv_op   = conv_op_q;
  assign conv_din  = conv_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed scenarios plus a randomized soak checked
// against a transaction-level model (one op in flight, round-robin, gray arithmetic).
module tb_gray_conv_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_op, req_ready;
  logic [N*W-1:0] req_data;
  logic          conv_op;
  logic [W-1:0]  conv_din, conv_dout;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic          rsp_op;
  logic [W-1:0]  rsp_data;
  logic          rsp_ready;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
    .conv_op(conv_op), .conv_din(conv_din), .conv_dout(conv_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_op(rsp_op), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Bit-level converter standing in for the external registered converter.
  function automatic logic [W-1:0] conv_bits(input logic op, input logic [W-1:0] x);
    logic [W-1:0] r;
    r[W-1] = x[W-1];
    for (int i = W - 2; i >= 0; i--)
      r[i] = op ? (r[i+1] ^ x[i]) : (x[i+1] ^ x[i]);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) conv_dout <= '0;
    else        conv_dout <= conv_bits(conv_op, conv_din);
  end

  // Reference: b->g by arithmetic, g->b by searching for the binary whose gray code matches.
  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [W-1:0] ref_conv(input logic op, input logic [W-1:0] x);
    logic [W-1:0] r;
    if (!op) return ref_b2g(x);
    r = '0;
    for (int b = 0; b < (1 << W); b++)
      if (ref_b2g(W'(b)) == x) r = W'(b);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request and collects the first response within a bounded window.
  task automatic run_one(input int id, input logic op, input logic [W-1:0] d,
                         output logic [N-1:0] rdy, output int lat, output logic [IW-1:0] gid,
                         output logic gop, output logic [W-1:0] gdata);
    lat = -1; gid = '0; gop = 1'b0; gdata = '0;
    @(negedge clk);
    req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b1;
    req_valid[id] = 1'b1; req_op[id] = op; req_data[id*W +: W] = d;
    #1 rdy = req_ready;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = '0;
      if (rsp_valid && lat < 0) begin
        lat = k; gid = rsp_id; gop = rsp_op; gdata = rsp_data;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_op = '0; req_data = '1; rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({req_ready, conv_op, conv_din, rsp_valid, rsp_id, rsp_op, rsp_data, busy} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got ready=%b busy=%b rsp_valid=%b want all zero",
               req_ready, busy, rsp_valid);
    end
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({busy, rsp_valid, req_ready} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_release got busy=%b rsp_valid=%b ready=%b want 0", busy, rsp_valid, req_ready);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_single();
    logic [N-1:0] rdy; int lat; logic [IW-1:0] gid; logic gop; logic [W-1:0] gd;
    run_one(0, 1'b0, 8'h05, rdy, lat, gid, gop, gd);
    $display("single: id=%0d op=%0d data=%h lat=%0d", gid, gop, gd, lat);
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("FAIL single_ready got %b want 0001", rdy); end
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL single_latency got %0d want 3", lat); end
    vectors++;
    if ({gid, gop, gd} !== {2'd0, 1'b0, 8'h07}) begin
      miscompares++;
      $display("FAIL single_rsp got id=%0d op=%0d data=%h want id=0 op=0 data=07", gid, gop, gd);
    end
  endtask

  task automatic test_edges();
    int           ids [3] = '{1, 3, 2};
    logic         ops [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] din [3] = '{8'h07, 8'h80, 8'hFF};
    logic [W-1:0] dexp[3] = '{8'h05, 8'hFF, 8'h80};
    logic [N-1:0] rdy; int lat; logic [IW-1:0] gid; logic gop; logic [W-1:0] gd;
    for (int t = 0; t < 3; t++) begin
      run_one(ids[t], ops[t], din[t], rdy, lat, gid, gop, gd);
      $display("edges: id=%0d op=%0d in=%h out=%h lat=%0d", gid, gop, din[t], gd, lat);
      vectors++;
      if ({gid, gop, gd} !== {2'(ids[t]), ops[t], dexp[t]} || lat !== 3) begin
        miscompares++;
        $display("FAIL edge_%0d got id=%0d op=%0d data=%h lat=%0d want id=%0d op=%0d data=%h lat=3",
                 t, gid, gop, gd, lat, ids[t], ops[t], dexp[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    @(negedge clk);
    req_valid = 4'b0010; req_op = 4'b0010; req_data = '0; req_data[1*W +: W] = 8'h3C; rsp_ready = 1'b0;
    while (!rsp_valid && k < 10) begin
      @(negedge clk); k++;
      req_valid = '0;
    end
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL reset_mid_reach got rsp_valid=%b want 1", rsp_valid); end
    req_valid = 4'b1000; req_data = '1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, conv_op, conv_din, rsp_valid, rsp_id, rsp_op, rsp_data, busy} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got ready=%b conv_din=%h rsp_valid=%b rsp_data=%h busy=%b want all zero",
               req_ready, conv_din, rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    req_valid = '0; req_data = '0; req_op = '0; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_no_rsp got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    $display("reset_mid: in-flight op discarded");
  endtask

  task automatic test_fairness();
    int seq[N] = '{0, 0, 0, 0};
    int grants[$]; int gcyc[$];
    logic [IW+W-1:0] expq[$];
    logic [IW+W-1:0] e;
    int g, nrsp = 0, cyc = 0, upd = -1;
    @(negedge clk);
    rsp_ready = 1'b1; req_op = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_data[i*W +: W] = {2'(i), 6'(seq[i])};
    end
    while ((grants.size() < 5 || nrsp < 5) && cyc < 60) begin
      #1;
      upd = -1;
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        grants.push_back(g); gcyc.push_back(cyc);
        expq.push_back({2'(g), req_data[g*W +: W]});
        seq[g]++; upd = g;
      end
      if (rsp_valid) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL fair_spurious got id=%0d data=%h want no response", rsp_id, rsp_data);
        end else begin
          e = expq.pop_front();
          $display("fair: id=%0d tag=%h data=%h", rsp_id, e[W-1:0], rsp_data);
          if ({rsp_id, rsp_data} !== {e[IW+W-1:W], ref_b2g(e[W-1:0])}) begin
            miscompares++;
            $display("FAIL fair_rsp got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, e[IW+W-1:W], ref_b2g(e[W-1:0]));
          end
        end
        nrsp++;
      end
      @(negedge clk); cyc++;
      if (upd >= 0) req_data[upd*W +: W] = {2'(upd), 6'(seq[upd])};
      if (grants.size() >= 5) req_valid = '0;
    end
    vectors++;
    if (grants.size() != 5) begin
      miscompares++;
      $display("FAIL fair_count got %0d grants want 5", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      vectors++;
      if (grants[i] !== (i % N)) begin
        miscompares++;
        $display("FAIL fair_order_%0d got %0d want %0d", i, grants[i], i % N);
      end
      if (i > 0) begin
        vectors++;
        if (gcyc[i] - gcyc[i-1] !== 4) begin
          miscompares++;
          $display("FAIL fair_spacing_%0d got %0d want 4", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IW+1+W-1:0] snap;
    int k = 0;
    @(negedge clk);
    req_valid = 4'b0001; req_op = '0; req_data = '0; req_data[0 +: W] = 8'hA5; rsp_ready = 1'b0;
    while (!rsp_valid && k < 10) begin
      @(negedge clk); k++;
      req_valid = '0;
    end
    snap = {rsp_id, rsp_op, rsp_data};
    vectors++;
    if (rsp_valid !== 1'b1 || snap !== {2'd0, 1'b0, 8'hF7}) begin
      miscompares++;
      $display("FAIL bp_rsp got valid=%b id=%0d op=%0d data=%h want valid=1 id=0 op=0 data=f7",
               rsp_valid, rsp_id, rsp_op, rsp_data);
    end
    req_valid = 4'b0010; req_op = 4'b0010; req_data[1*W +: W] = 8'h5A;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      vectors++;
      if ({rsp_valid, rsp_id, rsp_op, rsp_data} !== {1'b1, snap} || req_ready !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b busy=%b want 1 %h 0000 1",
                 c, rsp_valid, rsp_data, req_ready, busy, snap[W-1:0]);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_handshake_ready got %b want 0000", req_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_next_accept got valid=%b ready=%b want 0 0010", rsp_valid, req_ready);
    end
    $display("backpressure: held 5 cycles, released, next accept ready=%b", req_ready);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_soak();
    localparam int NOPS = 3000;
    bit           pend[N];
    logic         pop [N];
    logic [W-1:0] pdat[N];
    logic [IW+1+W-1:0] expq[$];
    logic [IW+1+W-1:0] e;
    logic [N-1:0] exp_rdy;
    int rr = 0, issued = 0, done = 0, cyc = 0, g;
    bit in_flight = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pop[i] = 1'b0; pdat[i] = '0; end
    while ((issued < NOPS || in_flight) && cyc < 60000) begin
      @(negedge clk); cyc++;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 31) == 0) pend[i] = 1'b0;
        end else if (issued < NOPS && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pop[i]  = 1'($urandom_range(0, 1));
          pdat[i] = W'($urandom_range(0, 255));
        end
        req_valid[i] = pend[i];
        req_op[i] = pop[i];
        req_data[i*W +: W] = pdat[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = '0; g = -1;
      if (!in_flight)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
      if (g >= 0) exp_rdy[g] = 1'b1;
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL soak_grant cycle %0d got %b want %b", cyc, req_ready, exp_rdy);
      end
      vectors++;
      if (busy !== in_flight) begin
        miscompares++;
        $display("FAIL soak_busy cycle %0d got %b want %b", cyc, busy, in_flight);
      end
      if (rsp_valid) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL soak_spurious cycle %0d got id=%0d data=%h want none", cyc, rsp_id, rsp_data);
        end else begin
          e = expq[0];
          if ({rsp_id, rsp_op, rsp_data} !== e) begin
            miscompares++;
            $display("FAIL soak_rsp cycle %0d got id=%0d op=%0d data=%h want id=%0d op=%0d data=%h",
                     cyc, rsp_id, rsp_op, rsp_data, e[IW+W], e[W], e[W-1:0]);
          end
          if (rsp_ready) begin
            void'(expq.pop_front());
            in_flight = 1'b0;
            done++;
            $display("soak: #%0d id=%0d op=%0d data=%h", done, rsp_id, rsp_op, rsp_data);
          end
        end
      end
      if (g >= 0) begin
        expq.push_back({2'(g), pop[g], ref_conv(pop[g], pdat[g])});
        rr = (g + 1) % N;
        pend[g] = 1'b0;
        in_flight = 1'b1;
        issued++;
      end
    end
    @(negedge clk);
    req_valid = '0;
    vectors++;
    if (done !== issued || expq.size() != 0 || issued < NOPS) begin
      miscompares++;
      $display("FAIL soak_count got done=%0d issued=%0d left=%0d want all %0d served",
               done, issued, expq.size(), NOPS);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_edges();
    test_reset_mid();
    test_fairness();
    test_backpressure();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
